fact_sched: RTL and testbench

- Round-robin scheduler that shares one factorial engine among NREQ requesters.
- The engine uses a level start/done handshake: it holds done while start stays high, and returns to idle once start drops.
- fact_sched arbitrates requests, captures the winner's operand, and sequences the engine handshake. It also bypasses the engine for xin 0 and 1, flags 16-bit overflow, and guards against a hung engine with a watchdog.
- Sits between the requesting clients and the single engine instance.

---
 rtl/fact_sched.sv | 180 ++++++++++++++++++
 tb/tb_fact_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fact_sched.sv
// Round-robin front end that shares one factorial engine among NREQ clients.
// Handles the engine's level start/done handshake, the 0!/1! bypass, overflow flagging and a hang watchdog.
module fact_sched #(
    parameter int NREQ = 4,
    parameter int N    = 4,
    parameter int TMO  = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] xin_bus,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              resp_valid,
    output logic [2:0]        resp_id,
    output logic [15:0]       resp_data,
    output logic              resp_ovf,
    output logic              resp_err,
    output logic              eng_start,
    output logic [N-1:0]      eng_xin,
    input  logic              eng_done,
    input  logic [15:0]       eng_fact
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [7:0]     WD_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {IDLE, START, RELEASE, RESP} state_t;

    state_t            state_q;
    logic [IDW-1:0]    rr_q;
    logic [IDW-1:0]    id_q;
    logic [N-1:0]      xin_q;
    logic [15:0]       res_q;
    logic              err_q;
    logic [7:0]        wdog_q;

    logic [NREQ-1:0]   grant_q;
    logic              busy_q;
    logic              resp_valid_q;
    logic [2:0]        resp_id_q;
    logic [15:0]       resp_data_q;
    logic              resp_ovf_q;
    logic              resp_err_q;
    logic              eng_start_q;
    logic [N-1:0]      eng_xin_q;

    logic [N-1:0]      xin_arr [NREQ];
    logic [2*NREQ-1:0] req_rot;
    logic              arb_found;
    logic [IDW-1:0]    arb_off;
    logic [IDW:0]      arb_sum;
    logic [IDW-1:0]    arb_id;
    logic [IDW-1:0]    arb_next;
    logic [N-1:0]      arb_xin;
    logic              arb_bypass;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_xin
            assign xin_arr[g] = xin_bus[g*N +: N];
        end
    endgenerate

    // Rotate requests so bit 0 is the rr pointer; lowest set bit of the rotated view wins.
    always_comb begin
        req_rot   = {req, req} >> rr_q;
        arb_found = 1'b0;
        arb_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_found = 1'b1;
                arb_off   = IDW'(k);
            end
        end
        arb_sum = {1'b0, rr_q} + {1'b0, arb_off};
        if (arb_sum >= NREQ_W) begin
            arb_sum = arb_sum - NREQ_W;
        end
        arb_id     = arb_sum[IDW-1:0];
        arb_next   = (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
        arb_xin    = xin_arr[arb_id];
        arb_bypass = (arb_xin <= N'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            id_q         <= '0;
            xin_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_ovf_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_xin_q    <= '0;
        end else begin
            grant_q      <= '0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A stale done (e.g. after an aborted START) holds off new engine jobs.
                    if (arb_found && (arb_bypass || !eng_done)) begin
                        grant_q <= NREQ'(1) << arb_id;
                        rr_q    <= arb_next;
                        id_q    <= arb_id;
                        xin_q   <= arb_xin;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (arb_bypass) begin
                            res_q   <= 16'd1;
                            state_q <= RESP;
                        end else begin
                            eng_xin_q   <= arb_xin;
                            eng_start_q <= 1'b1;
                            wdog_q      <= '0;
                            state_q     <= START;
                        end
                    end
                end
                START: begin
                    if (eng_done) begin
                        res_q       <= eng_fact;
                        eng_start_q <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= RELEASE;
                    end else if (wdog_q == WD_LAST) begin
                        eng_start_q <= 1'b0;
                        res_q       <= '0;
                        err_q       <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!eng_done) begin
                        state_q <= RESP;
                    end else if (wdog_q == WD_LAST) begin
                        res_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_id_q    <= 3'(id_q);
                    resp_data_q  <= res_q;
                    resp_ovf_q   <= (int'(xin_q) > 8);
                    resp_err_q   <= err_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_err   = resp_err_q;
    assign eng_start  = eng_start_q;
    assign eng_xin    = eng_xin_q;

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched with a behavioural factorial engine (fixed latency, optional hang).
module tb_fact_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] xin_bus;
    logic [3:0]  grant;
    logic        busy;
    logic        resp_valid;
    logic [2:0]  resp_id;
    logic [15:0] resp_data;
    logic        resp_ovf;
    logic        resp_err;
    logic        eng_start;
    logic [3:0]  eng_xin;
    logic        eng_done;
    logic [15:0] eng_fact;

    int vectors;
    int miscompares;
    logic hang;
    logic saw_start;
    int   ecnt;

    fact_sched #(.NREQ(4), .N(4), .TMO(63)) dut (
        .clk(clk), .reset(reset), .req(req), .xin_bus(xin_bus),
        .grant(grant), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_err(resp_err),
        .eng_start(eng_start), .eng_xin(eng_xin), .eng_done(eng_done), .eng_fact(eng_fact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fact16(input logic [3:0] x);
        logic [31:0] f;
        f = 32'd1;
        for (int i = 2; i <= int'(x); i++) f = f * 32'(i);
        return f[15:0];
    endfunction

    // Engine: done rises 3 cycles after start, holds while start is high, drops once start falls.
    initial begin
        eng_done = 1'b0;
        eng_fact = '0;
        ecnt     = 0;
        forever begin
            @(negedge clk);
            if (reset || hang || !eng_start) begin
                eng_done = 1'b0;
                ecnt     = 0;
            end else if (!eng_done) begin
                ecnt = ecnt + 1;
                if (ecnt >= 3) begin
                    eng_done = 1'b1;
                    eng_fact = fact16(eng_xin);
                end
            end
        end
    end

    initial begin
        saw_start = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start) saw_start = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget && grant === 4'b0000; i++) @(negedge clk);
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget && resp_valid !== 1'b1; i++) @(negedge clk);
    endtask

    logic [3:0]  rr_grant [5];
    logic [15:0] rr_data  [5];
    logic        saw_resp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        hang        = 1'b0;
        reset       = 1'b1;
        req         = 4'b0000;
        xin_bus     = 16'h0000;
        rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_data  = '{16'd6, 16'd24, 16'd2, 16'd720, 16'd6};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {grant, busy, resp_valid, resp_id, resp_data, resp_ovf,
                              resp_err, eng_start, eng_xin}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Round robin: all four held, operands 3,4,2,6.
        xin_bus = 16'h6243;
        req     = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(20);
            chk("rr_grant", 32'(grant), 32'(rr_grant[n]));
            if (n == 4) req = 4'b0000;
            wait_resp(40);
            chk("rr_resp_data", 32'(resp_data), 32'(rr_data[n]));
            chk("rr_resp_err", 32'(resp_err), 32'd0);
        end
        @(negedge clk);

        // Single request xin0 = 5.
        xin_bus = 16'h0005;
        req     = 4'b0001;
        wait_grant(10);
        chk("single_grant", 32'(grant), 32'b0001);
        chk("single_start", {27'd0, eng_start, eng_xin}, {27'd0, 1'b1, 4'd5});
        chk("single_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("single_grant_pulse", 32'(grant), 32'd0);
        wait_resp(40);
        chk("single_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                           {1'b1, 3'd0, 16'd120, 1'b0, 1'b0});
        chk("single_start_low", 32'(eng_start), 32'd0);
        @(negedge clk);
        chk("single_valid_pulse", 32'(resp_valid), 32'd0);

        // Bypass: xin2 = 1 then 0, exact two-edge latency, engine untouched.
        saw_start = 1'b0;
        for (int v = 1; v >= 0; v--) begin
            xin_bus = 16'(v) << 8;
            req     = 4'b0100;
            @(negedge clk);
            chk("bypass_grant", 32'(grant), 32'b0100);
            req = 4'b0000;
            @(negedge clk);
            chk("bypass_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                               {1'b1, 3'd2, 16'd1, 1'b0, 1'b0});
            @(negedge clk);
        end
        chk("bypass_no_start", 32'(saw_start), 32'd0);

        // Overflow: xin3 = 9 -> 362880 mod 65536.
        xin_bus = 16'h9000;
        req     = 4'b1000;
        wait_grant(10);
        chk("ovf_grant", 32'(grant), 32'b1000);
        req = 4'b0000;
        wait_resp(40);
        chk("ovf_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                        {1'b1, 3'd3, 16'd35200, 1'b1, 1'b0});
        @(negedge clk);

        // Hung engine: abort after 63 START cycles.
        hang    = 1'b1;
        xin_bus = 16'h0040;
        req     = 4'b0010;
        wait_grant(10);
        chk("hang_grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        repeat (62) @(negedge clk);
        chk("hang_start_held", {resp_valid, eng_start}, {1'b0, 1'b1});
        @(negedge clk);
        chk("hang_start_drop", {resp_valid, eng_start}, {1'b0, 1'b0});
        @(negedge clk);
        chk("hang_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                         {1'b1, 3'd1, 16'd0, 1'b0, 1'b1});
        hang = 1'b0;
        @(negedge clk);
        xin_bus = 16'h0003;
        req     = 4'b0001;
        wait_grant(10);
        chk("after_hang_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        wait_resp(40);
        chk("after_hang_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                               {1'b1, 3'd0, 16'd6, 1'b0, 1'b0});
        @(negedge clk);

        // Async reset in START with xin2 = 7.
        xin_bus = 16'h0700;
        req     = 4'b0100;
        wait_grant(10);
        chk("rst_mid_grant", 32'(grant), 32'b0100);
        @(negedge clk);
        chk("rst_mid_start", 32'(eng_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {grant, busy, resp_valid, resp_id, resp_data, resp_ovf,
                                resp_err, eng_start, eng_xin}, 32'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        saw_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        chk("rst_no_resp", 32'(saw_resp), 32'd0);
        xin_bus = 16'h0030;
        req     = 4'b0010;
        wait_grant(10);
        chk("post_rst_grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        wait_resp(40);
        chk("post_rst_resp", {resp_valid, resp_id, resp_data, resp_ovf, resp_err},
                             {1'b1, 3'd1, 16'd6, 1'b0, 1'b0});
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
